// File: rtl/decode_controller_if.sv
// Instruction-field and decode-control bundle between the ID stage and the decoder.
// The decoder sits on the slave side; the stage feeding it instruction fields is the master.
interface decode_controller_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       ex_alu_src;
    logic       mem_write;
    logic [2:0] mem_load_type;
    logic [1:0] mem_store_type;
    logic       wb_load;
    logic       wb_reg_file;
    logic       invalid_inst;
    logic       illegal_sticky;

    modport master (
        output opcode, func3, func7,
        input  ex_alu_src, mem_write, mem_load_type, mem_store_type,
        input  wb_load, wb_reg_file, invalid_inst, illegal_sticky
    );

    modport slave (
        input  opcode, func3, func7,
        output ex_alu_src, mem_write, mem_load_type, mem_store_type,
        output wb_load, wb_reg_file, invalid_inst, illegal_sticky
    );
endinterface

// File: rtl/decode_controller.sv
// RV32I ID-stage control decoder: combinational EX/MEM/WB control bits plus a
// sticky illegal-instruction flag that feeds the trap logic.
module decode_controller (
    input  logic                clk,
    input  logic                rst,
    decode_controller_if.slave  dec
);

    localparam logic [1:0] STORE_SB   = 2'b00;
    localparam logic [1:0] STORE_SH   = 2'b01;
    localparam logic [1:0] STORE_SW   = 2'b10;
    localparam logic [1:0] STORE_NONE = 2'b11;

    localparam logic [2:0] LOAD_LB    = 3'b000;
    localparam logic [2:0] LOAD_LH    = 3'b001;
    localparam logic [2:0] LOAD_LW    = 3'b010;
    localparam logic [2:0] LOAD_LBU   = 3'b100;
    localparam logic [2:0] LOAD_LHU   = 3'b101;
    localparam logic [2:0] LOAD_NONE  = 3'b111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic       alu_src;
    logic       mem_wr;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic       wb_ld;
    logic       reg_wr;
    logic       legal;

    logic       illegal_sticky_q;
    logic       illegal_sticky_d;

    always_comb begin
        alu_src    = 1'b0;
        mem_wr     = 1'b0;
        load_type  = LOAD_NONE;
        store_type = STORE_NONE;
        wb_ld      = 1'b0;
        reg_wr     = 1'b0;
        legal      = 1'b1;

        unique case (dec.opcode)
            OP_R: begin
                reg_wr = 1'b1;
                legal  = (dec.func7 == F7_BASE) ||
                         ((dec.func7 == F7_ALT) &&
                          ((dec.func3 == 3'b000) || (dec.func3 == 3'b101)));
            end
            OP_I_ALU: begin
                alu_src = 1'b1;
                reg_wr  = 1'b1;
                if (dec.func3 == 3'b001)
                    legal = (dec.func7 == F7_BASE);
                else if (dec.func3 == 3'b101)
                    legal = (dec.func7 == F7_BASE) || (dec.func7 == F7_ALT);
            end
            OP_LOAD: begin
                alu_src   = 1'b1;
                wb_ld     = 1'b1;
                reg_wr    = 1'b1;
                load_type = dec.func3;
                case (dec.func3)
                    LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: legal = 1'b1;
                    default:                                     legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                alu_src = 1'b1;
                mem_wr  = 1'b1;
                case (dec.func3)
                    3'b000:  store_type = STORE_SB;
                    3'b001:  store_type = STORE_SH;
                    3'b010:  store_type = STORE_SW;
                    default: legal      = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                legal = (dec.func3 != 3'b010) && (dec.func3 != 3'b011);
            end
            OP_JALR: begin
                alu_src = 1'b1;
                reg_wr  = 1'b1;
                legal   = (dec.func3 == 3'b000);
            end
            OP_JAL, OP_AUIPC, OP_LUI: begin
                alu_src = 1'b1;
                reg_wr  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // An illegal encoding must not reach EX/MEM/WB with any side effect.
    always_comb begin
        dec.ex_alu_src     = legal ? alu_src    : 1'b0;
        dec.mem_write      = legal ? mem_wr     : 1'b0;
        dec.mem_load_type  = legal ? load_type  : LOAD_NONE;
        dec.mem_store_type = legal ? store_type : STORE_NONE;
        dec.wb_load        = legal ? wb_ld      : 1'b0;
        dec.wb_reg_file    = legal ? reg_wr     : 1'b0;
        dec.invalid_inst   = ~legal;
    end

    assign illegal_sticky_d = illegal_sticky_q | ~legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_sticky_q <= 1'b0;
        else
            illegal_sticky_q <= illegal_sticky_d;
    end

    assign dec.illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_decode_controller.sv
// Randomized bench for decode_controller against a rule-level reference model,
// with literal expectations for the directed cases and the sticky flag.
module tb_decode_controller;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    decode_controller_if bus ();

    decode_controller dut (
        .clk (clk),
        .rst (rst),
        .dec (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {alu_src, mem_write, load_type[2:0], store_type[1:0], wb_load, wb_reg_file, invalid}
    localparam logic [9:0] ILLEGAL_VEC = 10'b0011111001;

    function automatic logic [9:0] model(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        bit         ok;
        bit         alu;
        bit         mw;
        bit         wl;
        bit         wr;
        logic [2:0] lt;
        logic [1:0] st;
        ok = 1; alu = 0; mw = 0; wl = 0; wr = 0; lt = 3'b111; st = 2'b11;
        case (op)
            7'h33: begin
                wr = 1;
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                alu = 1; wr = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
            end
            7'h03: begin
                alu = 1; wl = 1; wr = 1; lt = f3;
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            end
            7'h23: begin
                alu = 1; mw = 1;
                ok = (f3 < 3);
                st = f3[1:0];
            end
            7'h63: ok = !(f3 == 2 || f3 == 3);
            7'h6F, 7'h17, 7'h37: begin alu = 1; wr = 1; end
            7'h67: begin alu = 1; wr = 1; ok = (f3 == 0); end
            default: ok = 0;
        endcase
        if (!ok) return ILLEGAL_VEC;
        return {alu, mw, lt, st, wl, wr, 1'b0};
    endfunction

    logic [9:0] exp_now;
    logic [9:0] act_now;
    logic       sticky_m;

    assign exp_now = model(bus.opcode, bus.func3, bus.func7);
    assign act_now = {bus.ex_alu_src, bus.mem_write, bus.mem_load_type, bus.mem_store_type,
                      bus.wb_load, bus.wb_reg_file, bus.invalid_inst};

    always @(posedge clk or posedge rst) begin
        if (rst)
            sticky_m <= 1'b0;
        else if (exp_now[0])
            sticky_m <= 1'b1;
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (op=%h f3=%0d f7=%h)",
                     name, act, exp, bus.opcode, bus.func3, bus.func7);
        end
    endtask

    task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.opcode = op;
        bus.func3  = f3;
        bus.func7  = f7;
    endtask

    task automatic directed(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [9:0] exp);
        @(negedge clk);
        apply(op, f3, f7);
        #1;
        check(name, act_now, exp);
        check({name, "_model"}, exp_now, exp);
    endtask

    logic [6:0] legal_ops [9];
    logic [6:0] op_r;
    logic [6:0] f7_r;

    initial begin
        vectors     = 0;
        miscompares = 0;
        legal_ops   = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37};
        apply(7'h33, 3'b000, 7'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("sticky_in_reset", {9'd0, bus.illegal_sticky}, 10'd0);
        rst = 1'b0;

        // Sticky flag: stays clear on legal code, sets on illegal, holds until reset.
        repeat (2) @(negedge clk);
        #1;
        check("sticky_after_reset", {9'd0, bus.illegal_sticky}, 10'd0);
        apply(7'h7F, 3'b111, 7'h7F);
        @(negedge clk);
        #1;
        check("sticky_set", {9'd0, bus.illegal_sticky}, 10'd1);
        apply(7'h13, 3'b000, 7'h00);
        repeat (2) @(negedge clk);
        #1;
        check("sticky_hold", {9'd0, bus.illegal_sticky}, 10'd1);
        #2;
        rst = 1'b1;
        #1;
        check("sticky_async_clear", {9'd0, bus.illegal_sticky}, 10'd0);
        apply(7'h7F, 3'b111, 7'h7F);
        @(negedge clk);
        #1;
        check("sticky_held_in_reset", {9'd0, bus.illegal_sticky}, 10'd0);
        apply(7'h33, 3'b000, 7'h00);
        rst = 1'b0;

        directed("r_add",      7'h33, 3'b000, 7'h00, 10'b0011111010);
        directed("r_sub",      7'h33, 3'b000, 7'h20, 10'b0011111010);
        directed("r_bad_f7",   7'h33, 3'b001, 7'h20, ILLEGAL_VEC);
        directed("i_addi",     7'h13, 3'b000, 7'h55, 10'b1011111010);
        directed("i_slli_bad", 7'h13, 3'b001, 7'h20, ILLEGAL_VEC);
        directed("ld_lw",      7'h03, 3'b010, 7'h00, 10'b1001011110);
        directed("ld_bad",     7'h03, 3'b011, 7'h00, ILLEGAL_VEC);
        directed("st_sb",      7'h23, 3'b000, 7'h00, 10'b1111100000);
        directed("st_sh",      7'h23, 3'b001, 7'h00, 10'b1111101000);
        directed("st_sw",      7'h23, 3'b010, 7'h00, 10'b1111110000);
        directed("st_bad",     7'h23, 3'b011, 7'h00, ILLEGAL_VEC);
        directed("br_beq",     7'h63, 3'b000, 7'h00, 10'b0011111000);
        directed("br_bad",     7'h63, 3'b010, 7'h00, ILLEGAL_VEC);
        directed("jal",        7'h6F, 3'b101, 7'h3C, 10'b1011111010);
        directed("auipc",      7'h17, 3'b110, 7'h11, 10'b1011111010);
        directed("lui",        7'h37, 3'b011, 7'h7F, 10'b1011111010);
        directed("jalr",       7'h67, 3'b000, 7'h00, 10'b1011111010);
        directed("jalr_bad",   7'h67, 3'b001, 7'h00, ILLEGAL_VEC);
        directed("op_7f",      7'h7F, 3'b111, 7'h7F, ILLEGAL_VEC);

        // Reset before the random phase so the sticky model starts from a known state.
        @(negedge clk);
        rst = 1'b1;
        apply(7'h33, 3'b000, 7'h00);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            op_r = ($urandom_range(0, 9) < 9) ? legal_ops[$urandom_range(0, 8)]
                                               : 7'($urandom);
            case ($urandom_range(0, 2))
                0:       f7_r = 7'h00;
                1:       f7_r = 7'h20;
                default: f7_r = 7'($urandom);
            endcase
            // Keep illegal code rare so the sticky bit spends time clear.
            if (exp_now[0] == 1'b0 && $urandom_range(0, 3) != 0 && model(op_r, 3'($urandom), f7_r) == ILLEGAL_VEC)
                op_r = 7'h13;
            apply(op_r, 3'($urandom), f7_r);
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("rand_sticky_rst", {9'd0, bus.illegal_sticky}, 10'd0);
                rst = 1'b0;
            end
            #1;
            check("rand_decode", act_now, exp_now);
            check("rand_sticky", {9'd0, bus.illegal_sticky}, {9'd0, sticky_m});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
